cluster_unpacker: RTL
=====================

# cluster_unpacker

Frame-based cluster decoder: the inverse of the cluster priority encoder. It accepts a stream of (address, count) cluster words over a valid/ready handshake and rebuilds per-frame `vpfs`/`cnts` vectors, plus an expanded pad-hit mask. Frames end on a `last` flag. It sits on the receive side of the cluster link, where it feeds loopback checking and the trigger-emulation path.

## Interface
- `MXKEYS`, 192, pads per partition (192 or 384)
- `MXKEYBITS`, 8, address width (8 for 192, 9 for 384)
- `MXCNTB`, 3, count width; cluster size is `cnt+1` pads
- `MXCLST`, 15, max clusters per frame; a cluster counter of 4 bits saturates at 15
- `clock`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `clst_valid_i`  in  1  cluster word valid
- `clst_ready_o`  out  1  block can accept a word
- `clst_adr_i`  in  MXKEYBITS  cluster start pad
- `clst_cnt_i`  in  MXCNTB  cluster size minus one
- `clst_last_i`  in  1  final word of frame
- `pass_i`  in  3  frame tag, sampled on the first accepted word of a frame
- `frame_valid_o`  out  1  one-cycle pulse; the frame outputs are valid
- `pass_o`  out  3  frame tag
- `vpfs_o`  out  MXKEYS  cluster-start flags
- `cnts_o`  out  MXKEYS*MXCNTB  count at each start pad, 0 elsewhere
- `hits_o`  out  MXKEYS  expanded pad mask
- `nclst_o`  out  4  accepted clusters in frame, saturating
- `drop_o`  out  1  frame contained an invalid address
- `dup_o`  out  1  frame contained a repeated start address

## Operation
- FSM has two states, ACCUM (the reset state) and EMIT.
- ACCUM
  - `clst_ready_o`=1.
  - A word is accepted when `clst_valid_i`=1 and `clst_ready_o`=1.
  - On an accepted word with `clst_adr_i < MXKEYS`:
    - set `vpf_acc[adr]`;
    - write `cnt_acc[adr]=cnt`, last write wins;
    - OR the mask of bits `adr..min(adr+cnt, MXKEYS-1)` into `hit_acc`;
    - increment `nclst`, saturating at 15.
  - If `vpf_acc[adr]` is already set, set sticky `dup`.
  - A word with `clst_adr_i >= MXKEYS` (including the all-ones "no cluster" sentinel) leaves the accumulators, `hit_acc` and `nclst` untouched and sets sticky `drop`.
  - The first accepted word of a frame latches `pass_i`.
  - An accepted word with `clst_last_i`=1 moves the FSM to EMIT.
  - A frame may be empty: a single sentinel word with last=1 yields all-zero vectors and `drop_o`=1.
- EMIT (exactly one cycle)
  - `clst_ready_o`=0.
  - `frame_valid_o`=1; all frame outputs are driven from the accumulators.
  - Next cycle: clear the accumulators, `nclst`, `dup` and `drop`; return to ACCUM.
- Frame outputs hold their last emitted value until the next EMIT. Only `frame_valid_o` qualifies them.
- Reset values: `clst_ready_o`=0 while `reset_n`=0 and 1 after release; `frame_valid_o`=0; `pass_o`=0; `vpfs_o`=0; `cnts_o`=0; `hits_o`=0; `nclst_o`=0; `drop_o`=0; `dup_o`=0; FSM=ACCUM.
- Reset asserted mid-frame discards the partial frame; no `frame_valid_o` is produced for it.

## Timing
- Latency: `frame_valid_o` rises on the clock edge after the edge that accepts the last word.
- Throughput: one word per cycle in ACCUM, with one bubble per frame (the EMIT cycle).
- The upstream must hold `clst_valid_i` and the word stable while `clst_ready_o`=0.
- Outputs are registered. The mask-generation path from `adr`/`cnt` to `hit_acc` is combinational within the accept cycle.
- Address/count arithmetic is computed in MXKEYBITS+1 bits so that `adr+cnt` does not wrap; pads beyond `MXKEYS-1` are truncated, never wrapped to pad 0.

## Structure
- Shared package `cluster_pkg` holds:
  - the MXKEYS/MXKEYBITS/MXCNTB defaults for the 192 and 384 variants;
  - the sentinel address (all ones);
  - the FSM state typedef (ACCUM, EMIT).
- Sub-module `cluster_mask_gen`: combinational; maps (`adr`, `cnt`) to an MXKEYS-bit mask with truncation at the top pad. It is reused by the encoder testbench.

## Test plan
- Single cluster, adr=10, cnt=2, last=1:
  - response: `frame_valid_o` 1 cycle later; `vpfs_o` bit 10; `cnts_o[32:30]`=2; `hits_o` bits 10–12; `nclst_o`=1.
- Edge truncation, adr=190, cnt=7, MXKEYS=192:
  - response: `hits_o` bits 190–191 only; bit 0 stays clear.
- Sentinel handling, adr=255 with last=1:
  - response: all vectors zero, `drop_o`=1, `nclst_o`=0.
- Duplicate start, adr=5 cnt=1 then adr=5 cnt=4 (last):
  - response: `cnts_o` at pad 5 = 4, `hits_o` bits 5–9, `dup_o`=1, `nclst_o`=2.
- Back-to-back frames with `clst_valid_i` held high:
  - response: `clst_ready_o`=0 exactly in the EMIT cycle; the second frame carries no bits from the first and has its own `pass_o`.
- Reset asserted after 3 words of an unfinished frame:
  - response: no `frame_valid_o`; outputs return to 0; the next frame decodes cleanly.

Source files
------------

// File: rtl/cluster_pkg.sv
// Shared definitions for the cluster link: variant sizes, sentinel address
// and the unpacker FSM state type.
package cluster_pkg;

   localparam int MXKEYS_192    = 192;
   localparam int MXKEYBITS_192 = 8;
   localparam int MXKEYS_384    = 384;
   localparam int MXKEYBITS_384 = 9;
   localparam int MXCNTB_DEF    = 3;
   localparam int MXCLST        = 15;
   localparam int NCLSTB        = 4;

   // All-ones address marks "no cluster" on the link.
   localparam logic [MXKEYBITS_192-1:0] SENTINEL_ADR_192 = '1;
   localparam logic [MXKEYBITS_384-1:0] SENTINEL_ADR_384 = '1;

   typedef enum logic {
      ACCUM = 1'b0,
      EMIT  = 1'b1
   } state_t;

endpackage

// File: rtl/cluster_mask_gen.sv
// Combinational pad mask for one cluster: bits adr..adr+cnt, truncated at
// the top pad rather than wrapped.
module cluster_mask_gen
   import cluster_pkg::*;
#(
   parameter int MXKEYS    = MXKEYS_192,
   parameter int MXKEYBITS = MXKEYBITS_192,
   parameter int MXCNTB    = MXCNTB_DEF
) (
   input  logic [MXKEYBITS-1:0] i_adr,
   input  logic [MXCNTB-1:0]    i_cnt,
   output logic [MXKEYS-1:0]    o_mask
);

   localparam int AW = MXKEYBITS + 1;

   // One extra bit keeps adr+cnt from wrapping back onto low pads.
   logic [AW-1:0] w_lo;
   logic [AW-1:0] w_hi;

   assign w_lo = {1'b0, i_adr};
   assign w_hi = w_lo + AW'(i_cnt);

   always_comb begin
      o_mask = '0;
      for (int unsigned i = 0; i < MXKEYS; i++) begin
         o_mask[i] = (AW'(i) >= w_lo) && (AW'(i) <= w_hi);
      end
   end

endmodule

// File: rtl/cluster_unpacker.sv
// Rebuilds per-frame vpfs/cnts/hit vectors from a stream of (adr, cnt)
// cluster words; emits one frame per 'last' word.
module cluster_unpacker
   import cluster_pkg::*;
#(
   parameter int MXKEYS    = MXKEYS_192,
   parameter int MXKEYBITS = MXKEYBITS_192,
   parameter int MXCNTB    = MXCNTB_DEF
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     clst_valid_i,
   output logic                     clst_ready_o,
   input  logic [MXKEYBITS-1:0]     clst_adr_i,
   input  logic [MXCNTB-1:0]        clst_cnt_i,
   input  logic                     clst_last_i,
   input  logic [2:0]               pass_i,
   output logic                     frame_valid_o,
   output logic [2:0]               pass_o,
   output logic [MXKEYS-1:0]        vpfs_o,
   output logic [MXKEYS*MXCNTB-1:0] cnts_o,
   output logic [MXKEYS-1:0]        hits_o,
   output logic [NCLSTB-1:0]        nclst_o,
   output logic                     drop_o,
   output logic                     dup_o
);

   localparam int AW = MXKEYBITS + 1;

   state_t r_state;
   state_t w_state_nxt;

   logic                             r_ready;
   logic                             r_seen;
   logic [2:0]                       r_pass_acc;
   logic [MXKEYS-1:0]                r_vpf_acc;
   logic [MXKEYS-1:0][MXCNTB-1:0]    r_cnt_acc;
   logic [MXKEYS-1:0]                r_hit_acc;
   logic [NCLSTB-1:0]                r_nclst;
   logic                             r_dup;
   logic                             r_drop;

   logic                             r_frame_valid;
   logic [2:0]                       r_pass;
   logic [MXKEYS-1:0]                r_vpfs;
   logic [MXKEYS-1:0][MXCNTB-1:0]    r_cnts;
   logic [MXKEYS-1:0]                r_hits;
   logic [NCLSTB-1:0]                r_nclst_out;
   logic                             r_drop_out;
   logic                             r_dup_out;

   logic                             w_accept;
   logic                             w_adr_ok;
   logic [MXKEYS-1:0]                w_hit_mask;
   logic [2:0]                       w_pass_nxt;
   logic [MXKEYS-1:0]                w_vpf_nxt;
   logic [MXKEYS-1:0][MXCNTB-1:0]    w_cnt_nxt;
   logic [MXKEYS-1:0]                w_hit_nxt;
   logic [NCLSTB-1:0]                w_nclst_nxt;
   logic                             w_dup_nxt;
   logic                             w_drop_nxt;

   // r_ready is only ever set while in ACCUM, so it alone qualifies acceptance.
   assign w_accept = clst_valid_i & r_ready;
   assign w_adr_ok = ({1'b0, clst_adr_i} < AW'(MXKEYS));

   cluster_mask_gen #(
      .MXKEYS    (MXKEYS),
      .MXKEYBITS (MXKEYBITS),
      .MXCNTB    (MXCNTB)
   ) u_mask_gen (
      .i_adr  (clst_adr_i),
      .i_cnt  (clst_cnt_i),
      .o_mask (w_hit_mask)
   );

   always_comb begin
      w_pass_nxt  = r_seen ? r_pass_acc : pass_i;
      w_vpf_nxt   = r_vpf_acc;
      w_cnt_nxt   = r_cnt_acc;
      w_hit_nxt   = r_hit_acc;
      w_nclst_nxt = r_nclst;
      w_dup_nxt   = r_dup;
      w_drop_nxt  = r_drop;
      if (w_accept) begin
         if (w_adr_ok) begin
            if (r_vpf_acc[clst_adr_i]) w_dup_nxt = 1'b1;
            w_vpf_nxt[clst_adr_i] = 1'b1;
            w_cnt_nxt[clst_adr_i] = clst_cnt_i;
            w_hit_nxt             = r_hit_acc | w_hit_mask;
            if (r_nclst != NCLSTB'(MXCLST)) w_nclst_nxt = r_nclst + 4'd1;
         end else begin
            w_drop_nxt = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ACCUM:   if (w_accept && clst_last_i) w_state_nxt = EMIT;
         EMIT:    w_state_nxt = ACCUM;
         default: w_state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= ACCUM;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_ready       <= 1'b0;
         r_seen        <= 1'b0;
         r_pass_acc    <= '0;
         r_vpf_acc     <= '0;
         r_cnt_acc     <= '0;
         r_hit_acc     <= '0;
         r_nclst       <= '0;
         r_dup         <= 1'b0;
         r_drop        <= 1'b0;
         r_frame_valid <= 1'b0;
         r_pass        <= '0;
         r_vpfs        <= '0;
         r_cnts        <= '0;
         r_hits        <= '0;
         r_nclst_out   <= '0;
         r_drop_out    <= 1'b0;
         r_dup_out     <= 1'b0;
      end else begin
         r_ready       <= (w_state_nxt == ACCUM);
         r_frame_valid <= w_accept & clst_last_i;
         if (r_state == EMIT) begin
            r_seen    <= 1'b0;
            r_vpf_acc <= '0;
            r_cnt_acc <= '0;
            r_hit_acc <= '0;
            r_nclst   <= '0;
            r_dup     <= 1'b0;
            r_drop    <= 1'b0;
         end else if (w_accept) begin
            r_seen     <= 1'b1;
            r_pass_acc <= w_pass_nxt;
            r_vpf_acc  <= w_vpf_nxt;
            r_cnt_acc  <= w_cnt_nxt;
            r_hit_acc  <= w_hit_nxt;
            r_nclst    <= w_nclst_nxt;
            r_dup      <= w_dup_nxt;
            r_drop     <= w_drop_nxt;
         end
         // Outputs take the post-word accumulator so they are valid in EMIT.
         if (w_accept && clst_last_i) begin
            r_pass      <= w_pass_nxt;
            r_vpfs      <= w_vpf_nxt;
            r_cnts      <= w_cnt_nxt;
            r_hits      <= w_hit_nxt;
            r_nclst_out <= w_nclst_nxt;
            r_drop_out  <= w_drop_nxt;
            r_dup_out   <= w_dup_nxt;
         end
      end
   end

   assign clst_ready_o  = r_ready;
   assign frame_valid_o = r_frame_valid;
   assign pass_o        = r_pass;
   assign vpfs_o        = r_vpfs;
   assign cnts_o        = r_cnts;
   assign hits_o        = r_hits;
   assign nclst_o       = r_nclst_out;
   assign drop_o        = r_drop_out;
   assign dup_o         = r_dup_out;

endmodule
